// File: rtl/flick_conditioner.sv
// flick_conditioner: synchronises and debounces the flick push-button and
// turns each accepted press into one stretched, registered request for the
// LED sweep sequencer. The sequencer's ack ends the request early.
`timescale 1ns/1ps
module flick_conditioner #(
    parameter int DEB_CYCLES  = 20,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       ack,
    output logic       flick,
    output logic       btn_level,
    output logic [7:0] press_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS_DEB = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_REL  = 3'd3,
        ST_REL_DEB   = 3'd4
    } state_t;

    // Terminal counts: a press/release is accepted on the edge where the
    // counter already shows DEB_CYCLES-1 stable cycles.
    localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    state_t      r_state;
    logic [15:0] r_deb_cnt;
    logic [7:0]  r_hold_cnt;
    logic        r_flick;
    logic        r_btn_level;
    logic [7:0]  r_press_cnt;

    state_t      w_state_nxt;
    logic [15:0] w_deb_cnt_nxt;
    logic [7:0]  w_hold_cnt_nxt;
    logic        w_btn_level_nxt;
    logic [7:0]  w_press_cnt_nxt;

    // Two-flop synchroniser for the asynchronous button; only r_sync2 is used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state and counter decode; every value holds unless a transition changes it.
    always_comb begin
        w_state_nxt     = r_state;
        w_deb_cnt_nxt   = r_deb_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_btn_level_nxt = r_btn_level;
        w_press_cnt_nxt = r_press_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt   = ST_PRESS_DEB;
                    w_deb_cnt_nxt = 16'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS_DEB: begin
                if (!r_sync2) begin
                    // Bounce: abandon the press without counting it.
                    w_state_nxt = ST_IDLE;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt     = ST_HOLD;
                    w_btn_level_nxt = 1'b1;
                    w_press_cnt_nxt = r_press_cnt + 8'd1;
                    w_hold_cnt_nxt  = 8'd0;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 16'd1;
                end
            end
            ST_HOLD: begin
                // The button is deliberately not watched here, so a release
                // cannot cut the request short; ack wins over the hold timer.
                if (ack || (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nxt = ST_WAIT_REL;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            ST_WAIT_REL: begin
                if (!r_sync2) begin
                    w_state_nxt   = ST_REL_DEB;
                    w_deb_cnt_nxt = 16'd0;
                end else begin
                    w_state_nxt = ST_WAIT_REL;
                end
            end
            ST_REL_DEB: begin
                if (r_sync2) begin
                    // Bounce on release: keep treating the button as held.
                    w_state_nxt = ST_WAIT_REL;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_btn_level_nxt = 1'b0;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 16'd1;
                end
            end
            default: begin
                // Unreachable encodings recover to a quiet idle.
                w_state_nxt     = ST_IDLE;
                w_btn_level_nxt = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters and registered outputs; flick is registered from the next state
    // so it equals (state == HOLD) with no combinational path from the inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb_cnt   <= 16'd0;
            r_hold_cnt  <= 8'd0;
            r_flick     <= 1'b0;
            r_btn_level <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_flick     <= (w_state_nxt == ST_HOLD);
            r_btn_level <= w_btn_level_nxt;
            r_press_cnt <= w_press_cnt_nxt;
        end
    end

    assign flick     = r_flick;
    assign btn_level = r_btn_level;
    assign press_cnt = r_press_cnt;

endmodule
